// File: rtl/pixel_scheduler.sv
`timescale 1ns/1ps
// Frame scheduler: scans a WIDTH x HEIGHT raster, shares NUM_ENGINES depth engines
// and streams tagged (x, y, depth) results over a valid/ready port.
module pixel_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int DEPTH_W     = 11
) (
    input  logic                             sysclk,
    input  logic                             reset_n,
    input  logic                             frame_start,
    input  logic [DEPTH_W-1:0]               cfg_width,
    input  logic [DEPTH_W-1:0]               cfg_height,
    input  logic [WORD_LENGTH-1:0]           cfg_re_start,
    input  logic [WORD_LENGTH-1:0]           cfg_im_start,
    input  logic [WORD_LENGTH-1:0]           cfg_step,
    input  logic [DEPTH_W-1:0]               cfg_max_iter,
    output logic                             busy,
    output logic                             frame_done,
    output logic [NUM_ENGINES-1:0]           eng_start,
    output logic [NUM_ENGINES*WORD_LENGTH-1:0] eng_re_c,
    output logic [NUM_ENGINES*WORD_LENGTH-1:0] eng_im_c,
    output logic [DEPTH_W-1:0]               eng_max_iter,
    input  logic [NUM_ENGINES-1:0]           eng_done,
    input  logic [NUM_ENGINES*DEPTH_W-1:0]   eng_depth,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [DEPTH_W-1:0]               res_x,
    output logic [DEPTH_W-1:0]               res_y,
    output logic [DEPTH_W-1:0]               res_depth
);
    localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    if (NUM_ENGINES < 1 || NUM_ENGINES > 16 || FRAC >= WORD_LENGTH) begin : g_bad_cfg
        $error("pixel_scheduler: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                         state_q;
    logic                           busy_q, frame_done_q, res_valid_q;
    logic [NUM_ENGINES-1:0]         eng_start_q, eng_busy_q, slot_v_q;
    logic [NUM_ENGINES*WORD_LENGTH-1:0] eng_re_c_q, eng_im_c_q;
    logic [DEPTH_W-1:0]             max_iter_q, width_q, height_q, x_q, y_q;
    logic [DEPTH_W-1:0]             res_x_q, res_y_q, res_depth_q;
    logic [WORD_LENGTH-1:0]         re_start_q, step_q, cur_re_q, cur_im_q;
    logic [PW-1:0]                  rr_ptr_q, out_ptr_q, sel_q;
    logic [DEPTH_W-1:0]             tag_x_q [NUM_ENGINES];
    logic [DEPTH_W-1:0]             tag_y_q [NUM_ENGINES];
    logic [DEPTH_W-1:0]             slot_depth_q [NUM_ENGINES];
    logic [1:0]                     guard_q [NUM_ENGINES];

    logic [NUM_ENGINES-1:0]         free_d, avail_d;
    logic                           disp_ok_d, out_ok_d, handshake_d;
    logic [PW-1:0]                  disp_idx_d, out_idx_d, out_base_d;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NUM_ENGINES) s = s - NUM_ENGINES;
        return s[PW-1:0];
    endfunction

    always_comb begin
        free_d     = ~eng_busy_q & ~slot_v_q;
        disp_ok_d  = 1'b0;
        disp_idx_d = '0;
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            if (!disp_ok_d && free_d[wrap_add(rr_ptr_q, k)]) begin
                disp_ok_d  = 1'b1;
                disp_idx_d = wrap_add(rr_ptr_q, k);
            end
        end
    end

    // The slot being handed off this cycle is excluded so the next pick is ready one edge later.
    always_comb begin
        handshake_d = res_valid_q && res_ready;
        avail_d     = slot_v_q;
        if (handshake_d) avail_d[sel_q] = 1'b0;
        out_base_d  = handshake_d ? wrap_add(sel_q, 1) : out_ptr_q;
        out_ok_d    = 1'b0;
        out_idx_d   = '0;
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            if (!out_ok_d && avail_d[wrap_add(out_base_d, k)]) begin
                out_ok_d  = 1'b1;
                out_idx_d = wrap_add(out_base_d, k);
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            eng_start_q  <= '0;
            eng_re_c_q   <= '0;
            eng_im_c_q   <= '0;
            max_iter_q   <= '0;
            width_q      <= '0;
            height_q     <= '0;
            re_start_q   <= '0;
            step_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            cur_re_q     <= '0;
            cur_im_q     <= '0;
            rr_ptr_q     <= '0;
            out_ptr_q    <= '0;
            sel_q        <= '0;
            eng_busy_q   <= '0;
            slot_v_q     <= '0;
            res_valid_q  <= 1'b0;
            res_x_q      <= '0;
            res_y_q      <= '0;
            res_depth_q  <= '0;
            for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
                tag_x_q[i]      <= '0;
                tag_y_q[i]      <= '0;
                slot_depth_q[i] <= '0;
                guard_q[i]      <= '0;
            end
        end else begin
            eng_start_q  <= '0;
            frame_done_q <= 1'b0;

            for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
                if (guard_q[i] != 2'd0) begin
                    guard_q[i] <= guard_q[i] - 2'd1;
                end else if (eng_busy_q[i] && eng_done[i]) begin
                    slot_depth_q[i] <= eng_depth[i*DEPTH_W +: DEPTH_W];
                    slot_v_q[i]     <= 1'b1;
                    eng_busy_q[i]   <= 1'b0;
                end
            end

            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        width_q    <= cfg_width;
                        height_q   <= cfg_height;
                        re_start_q <= cfg_re_start;
                        step_q     <= cfg_step;
                        max_iter_q <= cfg_max_iter;
                        x_q        <= '0;
                        y_q        <= '0;
                        cur_re_q   <= cfg_re_start;
                        cur_im_q   <= cfg_im_start;
                        busy_q     <= 1'b1;
                        state_q    <= (cfg_width == '0 || cfg_height == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (disp_ok_d) begin
                        eng_start_q[disp_idx_d] <= 1'b1;
                        eng_re_c_q[int'(disp_idx_d)*WORD_LENGTH +: WORD_LENGTH] <= cur_re_q;
                        eng_im_c_q[int'(disp_idx_d)*WORD_LENGTH +: WORD_LENGTH] <= cur_im_q;
                        tag_x_q[disp_idx_d]    <= x_q;
                        tag_y_q[disp_idx_d]    <= y_q;
                        eng_busy_q[disp_idx_d] <= 1'b1;
                        guard_q[disp_idx_d]    <= 2'd2;
                        rr_ptr_q               <= wrap_add(disp_idx_d, 1);
                        if (x_q < width_q - 1'b1) begin
                            x_q      <= x_q + 1'b1;
                            cur_re_q <= cur_re_q + step_q;
                        end else begin
                            x_q      <= '0;
                            cur_re_q <= re_start_q;
                            y_q      <= y_q + 1'b1;
                            cur_im_q <= cur_im_q - step_q;
                            if (y_q == height_q - 1'b1) state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (eng_busy_q == '0 && slot_v_q == '0) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (handshake_d) begin
                slot_v_q[sel_q] <= 1'b0;
                out_ptr_q       <= wrap_add(sel_q, 1);
            end
            if (!(res_valid_q && !res_ready)) begin
                res_valid_q <= out_ok_d;
                if (out_ok_d) begin
                    sel_q       <= out_idx_d;
                    res_x_q     <= tag_x_q[out_idx_d];
                    res_y_q     <= tag_y_q[out_idx_d];
                    res_depth_q <= slot_depth_q[out_idx_d];
                end
            end
        end
    end

    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign eng_start    = eng_start_q;
    assign eng_re_c     = eng_re_c_q;
    assign eng_im_c     = eng_im_c_q;
    assign eng_max_iter = max_iter_q;
    assign res_valid    = res_valid_q;
    assign res_x        = res_x_q;
    assign res_y        = res_y_q;
    assign res_depth    = res_depth_q;
endmodule

// File: tb/tb_pixel_scheduler.sv
`timescale 1ns/1ps
// Bench for pixel_scheduler: raster model computing c by multiplication, engine models
// with differing latency, and a negedge compare process over dispatches and results.
module tb_pixel_scheduler;
    localparam int NE = 4;
    localparam int WL = 32;
    localparam int DW = 11;

    logic                 sysclk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 frame_start = 1'b0;
    logic [DW-1:0]        cfg_width = '0, cfg_height = '0, cfg_max_iter = '0;
    logic [WL-1:0]        cfg_re_start = '0, cfg_im_start = '0, cfg_step = '0;
    logic                 busy, frame_done, res_valid;
    logic [NE-1:0]        eng_start;
    logic [NE*WL-1:0]     eng_re_c, eng_im_c;
    logic [DW-1:0]        eng_max_iter, res_x, res_y, res_depth;
    logic [NE-1:0]        eng_done = '0;
    logic [NE*DW-1:0]     eng_depth = '0;
    logic                 res_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    bit          m_active = 1'b0;
    int          m_w, m_h, m_total, m_disp, m_res, m_done_cnt;
    logic [31:0] m_re0, m_im0, m_step;
    logic [10:0] m_iter;
    bit          seen [int];
    logic [31:0] log_re [$];
    logic [31:0] log_im [$];

    pixel_scheduler #(.NUM_ENGINES(NE), .WORD_LENGTH(WL), .FRAC(28), .DEPTH_W(DW)) dut (
        .sysclk(sysclk), .reset_n(reset_n), .frame_start(frame_start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_re_start(cfg_re_start),
        .cfg_im_start(cfg_im_start), .cfg_step(cfg_step), .cfg_max_iter(cfg_max_iter),
        .busy(busy), .frame_done(frame_done), .eng_start(eng_start),
        .eng_re_c(eng_re_c), .eng_im_c(eng_im_c), .eng_max_iter(eng_max_iter),
        .eng_done(eng_done), .eng_depth(eng_depth), .res_valid(res_valid),
        .res_ready(res_ready), .res_x(res_x), .res_y(res_y), .res_depth(res_depth)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] hash(input logic [31:0] re, input logic [31:0] im);
        logic [31:0] v;
        v = re ^ {im[15:0], im[31:16]};
        return v[10:0] ^ v[21:11] ^ {1'b0, v[31:22]};
    endfunction

    function automatic logic [31:0] exp_re(input int x);
        return m_re0 + 32'(x) * m_step;
    endfunction

    function automatic logic [31:0] exp_im(input int y);
        return m_im0 - 32'(y) * m_step;
    endfunction

    // Engine models: done stays high from the previous pixel until one cycle after start.
    bit          e_pend [NE];
    bit          e_run  [NE];
    int          e_cnt  [NE];
    logic [10:0] e_dep  [NE];
    initial forever begin
        @(negedge sysclk);
        for (int i = 0; i < NE; i++) begin
            if (!reset_n) begin
                e_pend[i] = 1'b0; e_run[i] = 1'b0; e_cnt[i] = 0;
                eng_done[i] = 1'b0;
            end else if (eng_start[i]) begin
                check("no_start_while_busy", {62'd0, e_pend[i], e_run[i]}, 64'd0);
                e_pend[i] = 1'b1;
                e_dep[i]  = hash(eng_re_c[i*WL +: WL], eng_im_c[i*WL +: WL]);
            end else if (e_pend[i]) begin
                e_pend[i]   = 1'b0;
                e_run[i]    = 1'b1;
                eng_done[i] = 1'b0;
                e_cnt[i]    = 1 + 2*i + int'(e_dep[i][1:0]);
            end else if (e_run[i]) begin
                if (e_cnt[i] == 0) begin
                    eng_done[i] = 1'b1;
                    eng_depth[i*DW +: DW] = e_dep[i];
                    e_run[i] = 1'b0;
                end else begin
                    e_cnt[i]--;
                end
            end
        end
    end

    bit            hold_v = 1'b0;
    logic [3*DW-1:0] held;
    initial forever begin
        @(negedge sysclk);
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            if (eng_start != '0) begin
                if (!m_active || m_disp >= m_total) begin
                    check("spurious_start", {60'd0, eng_start}, 64'd0);
                end else begin
                    int idx, x, y;
                    check("one_start_per_cycle", 64'($countones(eng_start)), 64'd1);
                    idx = 0;
                    for (int i = NE-1; i >= 0; i--) if (eng_start[i]) idx = i;
                    x = m_disp % m_w;
                    y = m_disp / m_w;
                    check("disp_re", 64'(eng_re_c[idx*WL +: WL]), 64'(exp_re(x)));
                    check("disp_im", 64'(eng_im_c[idx*WL +: WL]), 64'(exp_im(y)));
                    check("max_iter", 64'(eng_max_iter), 64'(m_iter));
                    log_re.push_back(eng_re_c[idx*WL +: WL]);
                    log_im.push_back(eng_im_c[idx*WL +: WL]);
                    m_disp++;
                end
            end
            if (hold_v) begin
                check("res_hold_valid", 64'(res_valid), 64'd1);
                check("res_hold_data", 64'({res_x, res_y, res_depth}), 64'(held));
            end
            hold_v = res_valid && !res_ready;
            held   = {res_x, res_y, res_depth};
            if (res_valid && res_ready) begin
                int key;
                key = int'(res_y) * 4096 + int'(res_x);
                check("res_in_frame", 64'(m_active && int'(res_x) < m_w && int'(res_y) < m_h), 64'd1);
                check("res_unique", 64'(seen.exists(key)), 64'd0);
                check("res_depth", 64'(res_depth), 64'(hash(exp_re(int'(res_x)), exp_im(int'(res_y)))));
                seen[key] = 1'b1;
                m_res++;
            end
            if (frame_done) begin
                check("done_in_frame", 64'(m_active), 64'd1);
                check("done_results", 64'(m_res), 64'(m_total));
                check("done_dispatches", 64'(m_disp), 64'(m_total));
                m_active = 1'b0;
                m_done_cnt++;
            end
            check("busy", 64'(busy), 64'(m_active));
        end
    end

    task automatic start_frame(input int w, input int h, input logic [31:0] re0,
                               input logic [31:0] im0, input logic [31:0] step,
                               input logic [10:0] iter);
        bit take;
        cfg_width = DW'(w); cfg_height = DW'(h); cfg_re_start = re0;
        cfg_im_start = im0; cfg_step = step; cfg_max_iter = iter;
        frame_start = 1'b1;
        take = !m_active;
        @(posedge sysclk); #1;
        frame_start = 1'b0;
        if (take) begin
            m_w = w; m_h = h; m_total = w * h; m_re0 = re0; m_im0 = im0; m_step = step;
            m_iter = iter; m_disp = 0; m_res = 0; m_done_cnt = 0;
            seen.delete(); log_re.delete(); log_im.delete();
            m_active = 1'b1;
        end
    endtask

    task automatic wait_frame(input int budget);
        int n;
        n = 0;
        while (m_active && n < budget) begin
            @(negedge sysclk); #1;
            n++;
        end
        check("frame_completes", 64'(m_active), 64'd0);
        m_active = 1'b0;
    endtask

    initial begin
        logic [3:0] fd;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_eng_start", 64'(eng_start), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        reset_n = 1'b1;
        res_ready = 1'b1;
        @(posedge sysclk); #1;

        // 2x2 frame at (-2, 1) with step 0.5
        start_frame(2, 2, 32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 11'd20);
        wait_frame(400);
        repeat (5) @(posedge sysclk);
        #1;
        check("t1_count", 64'(log_re.size()), 64'd4);
        if (log_re.size() == 4) begin
            check("t1_re0", 64'(log_re[0]), 64'hE000_0000);
            check("t1_im0", 64'(log_im[0]), 64'h1000_0000);
            check("t1_re1", 64'(log_re[1]), 64'hE800_0000);
            check("t1_im1", 64'(log_im[1]), 64'h1000_0000);
            check("t1_re2", 64'(log_re[2]), 64'hE000_0000);
            check("t1_im2", 64'(log_im[2]), 64'h0800_0000);
            check("t1_re3", 64'(log_re[3]), 64'hE800_0000);
            check("t1_im3", 64'(log_im[3]), 64'h0800_0000);
        end
        check("t1_done_pulses", 64'(m_done_cnt), 64'd1);

        // 8x1 line with step 0.25
        start_frame(8, 1, 32'hE000_0000, 32'h0000_0000, 32'h0400_0000, 11'd100);
        wait_frame(600);
        check("t2_results", 64'(m_res), 64'd8);

        // sink stalled: four engines fill their slots, then dispatch stops
        res_ready = 1'b0;
        start_frame(4, 2, 32'hF000_0000, 32'h0400_0000, 32'h0200_0000, 11'd33);
        repeat (60) @(posedge sysclk);
        #1;
        check("t3_disp_stalled", 64'(m_disp), 64'd4);
        check("t3_res_valid", 64'(res_valid), 64'd1);
        check("t3_busy", 64'(busy), 64'd1);
        res_ready = 1'b1;
        wait_frame(600);
        check("t3_results", 64'(m_res), 64'd8);

        // zero-width frame
        @(posedge sysclk); #1;
        cfg_width = '0; cfg_height = 11'd3; frame_start = 1'b1;
        @(negedge sysclk); fd[0] = frame_done;
        @(posedge sysclk); #1;
        frame_start = 1'b0;
        m_w = 0; m_h = 3; m_total = 0; m_disp = 0; m_res = 0; m_done_cnt = 0;
        seen.delete(); log_re.delete(); log_im.delete();
        m_active = 1'b1;
        @(negedge sysclk); fd[1] = frame_done;
        @(negedge sysclk); fd[2] = frame_done;
        @(negedge sysclk); fd[3] = frame_done;
        #1;
        check("t4_done_timing", 64'(fd), 64'b0100);
        check("t4_no_dispatch", 64'(log_re.size()), 64'd0);
        wait_frame(20);

        // asynchronous reset mid-frame
        start_frame(4, 4, 32'hE400_0000, 32'h0C00_0000, 32'h0100_0000, 11'd50);
        repeat (8) @(posedge sysclk);
        #2;
        reset_n = 1'b0;
        m_active = 1'b0;
        #1;
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_frame_done", 64'(frame_done), 64'd0);
        check("ar_eng_start", 64'(eng_start), 64'd0);
        check("ar_res_valid", 64'(res_valid), 64'd0);
        check("ar_eng_re_c", 64'(eng_re_c != '0), 64'd0);
        check("ar_eng_im_c", 64'(eng_im_c != '0), 64'd0);
        check("ar_max_iter", 64'(eng_max_iter), 64'd0);
        check("ar_res_data", 64'({res_x, res_y, res_depth}), 64'd0);
        @(posedge sysclk); @(posedge sysclk); #1;
        reset_n = 1'b1;
        @(posedge sysclk); #1;
        start_frame(2, 1, 32'h0C00_0000, 32'hFC00_0000, 32'h0100_0000, 11'd7);
        wait_frame(300);
        check("t5_results", 64'(m_res), 64'd2);
        if (log_re.size() > 0) begin
            check("t5_first_re", 64'(log_re[0]), 64'h0C00_0000);
            check("t5_first_im", 64'(log_im[0]), 64'hFC00_0000);
        end else begin
            check("t5_first_dispatch", 64'd0, 64'd1);
        end

        // frame_start re-pulsed during RUN is ignored
        start_frame(3, 3, 32'hF800_0000, 32'h0800_0000, 32'h0080_0000, 11'd15);
        repeat (3) @(posedge sysclk);
        #1;
        start_frame(5, 5, 32'h1000_0000, 32'h1000_0000, 32'h0400_0000, 11'd99);
        wait_frame(800);
        check("t6_results", 64'(m_res), 64'd9);

        repeat (5) @(posedge sysclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
